// File: rtl/lsp_az_combine_pkg.sv
// Shared constants for the Lsp_Az combine stage: FSM encodings, Q12 unity, rounding shift.
package lsp_az_combine_pkg;

  localparam logic [3:0] StIdle   = 4'd0;
  localparam logic [3:0] StA0     = 4'd1;
  localparam logic [3:0] StFixRd0 = 4'd2;
  localparam logic [3:0] StFixRd1 = 4'd3;
  localparam logic [3:0] StFixRd2 = 4'd4;
  localparam logic [3:0] StFixWr  = 4'd5;
  localparam logic [3:0] StCmbRd0 = 4'd6;
  localparam logic [3:0] StCmbRd1 = 4'd7;
  localparam logic [3:0] StCmbRd2 = 4'd8;
  localparam logic [3:0] StCmbWrp = 4'd9;
  localparam logic [3:0] StCmbWrm = 4'd10;
  localparam logic [3:0] StDone   = 4'd11;

  localparam logic [31:0] Q12_ONE     = 32'h0000_1000;
  localparam int unsigned L_SHR_R_AMT = 13;

  // L_shr_r(t,13) then extract_l and sign-extend. Argument is t[28:12]: the low 16 bits of
  // t>>>13 plus the rounding bit t[12]; the upper bits of t never reach the result.
  function automatic logic [31:0] rnd_q12(input logic [16:0] t_mid);
    logic [15:0] s;
    s = t_mid[16:1] + {15'b0, t_mid[0]};
    return {{16{s[15]}}, s};
  endfunction

endpackage

// File: rtl/lsp_az_combine.sv
// Lsp_Az tail: folds F1/F2 in place, then forms Q12 LPC coefficients a[0..10] in scratch memory.
module lsp_az_combine
  import lsp_az_combine_pkg::*;
#(
  parameter logic [10:0] F1_ADDR = 11'd0,
  parameter logic [10:0] F2_ADDR = 11'd6,
  parameter logic [10:0] A_ADDR  = 11'd12
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        done,
  output logic [10:0] scratch_mem_read_addr,
  input  logic [31:0] scratch_mem_out,
  output logic [10:0] scratch_mem_write_addr,
  output logic [31:0] scratch_mem_in,
  output logic        scratch_mem_write_en,
  output logic [31:0] L_add_outa,
  output logic [31:0] L_add_outb,
  input  logic [31:0] L_add_in,
  input  logic        L_add_overflow,
  output logic [31:0] L_sub_outa,
  output logic [31:0] L_sub_outb,
  input  logic [31:0] L_sub_in,
  input  logic        L_sub_overflow
);

  logic [3:0]  state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic        sel_q, sel_d;  // 0: F1 (L_add) pass, 1: F2 (L_sub) pass
  logic [31:0] add_a_q, add_b_q, sub_a_q, sub_b_q;
  logic [10:0] idx_ext, fix_base;
  logic        unused_ovf;

  assign unused_ovf = L_add_overflow ^ L_sub_overflow;
  assign idx_ext    = {8'b0, idx_q};
  assign fix_base   = sel_q ? F2_ADDR : F1_ADDR;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sel_d   = sel_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StA0;
          idx_d   = 3'd5;
          sel_d   = 1'b0;
        end
      end
      StA0:     state_d = StFixRd0;
      StFixRd0: state_d = StFixRd1;
      StFixRd1: state_d = StFixRd2;
      StFixRd2: state_d = StFixWr;
      StFixWr: begin
        if (idx_q != 3'd1) begin
          idx_d   = idx_q - 3'd1;
          state_d = StFixRd0;
        end else if (!sel_q) begin
          sel_d   = 1'b1;
          idx_d   = 3'd5;
          state_d = StFixRd0;
        end else begin
          idx_d   = 3'd1;
          state_d = StCmbRd0;
        end
      end
      StCmbRd0: state_d = StCmbRd1;
      StCmbRd1: state_d = StCmbRd2;
      StCmbRd2: state_d = StCmbWrp;
      StCmbWrp: state_d = StCmbWrm;
      StCmbWrm: begin
        if (idx_q == 3'd5) begin
          state_d = StDone;
        end else begin
          idx_d   = idx_q + 3'd1;
          state_d = StCmbRd0;
        end
      end
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      idx_q   <= 3'd0;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
    end
  end

  // Operand registers double as the x/y (FIX) and p/q (CMB) latches; the idle operator holds.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      add_a_q <= 32'd0;
      add_b_q <= 32'd0;
      sub_a_q <= 32'd0;
      sub_b_q <= 32'd0;
    end else begin
      case (state_q)
        StFixRd1: if (sel_q) sub_a_q <= scratch_mem_out; else add_a_q <= scratch_mem_out;
        StFixRd2: if (sel_q) sub_b_q <= scratch_mem_out; else add_b_q <= scratch_mem_out;
        StCmbRd1: begin
          add_a_q <= scratch_mem_out;
          sub_a_q <= scratch_mem_out;
        end
        StCmbRd2: begin
          add_b_q <= scratch_mem_out;
          sub_b_q <= scratch_mem_out;
        end
        default: ;
      endcase
    end
  end

  assign L_add_outa = add_a_q;
  assign L_add_outb = add_b_q;
  assign L_sub_outa = sub_a_q;
  assign L_sub_outb = sub_b_q;
  assign done       = (state_q == StDone);

  always_comb begin
    scratch_mem_read_addr  = 11'd0;
    scratch_mem_write_addr = 11'd0;
    scratch_mem_in         = 32'd0;
    scratch_mem_write_en   = 1'b0;
    case (state_q)
      StA0: begin
        scratch_mem_write_en   = 1'b1;
        scratch_mem_write_addr = A_ADDR;
        scratch_mem_in         = Q12_ONE;
      end
      StFixRd0: scratch_mem_read_addr = fix_base + idx_ext;
      StFixRd1: scratch_mem_read_addr = fix_base + idx_ext - 11'd1;
      StFixWr: begin
        scratch_mem_write_en   = 1'b1;
        scratch_mem_write_addr = fix_base + idx_ext;
        scratch_mem_in         = sel_q ? L_sub_in : L_add_in;
      end
      StCmbRd0: scratch_mem_read_addr = F1_ADDR + idx_ext;
      StCmbRd1: scratch_mem_read_addr = F2_ADDR + idx_ext;
      StCmbWrp: begin
        scratch_mem_write_en   = 1'b1;
        scratch_mem_write_addr = A_ADDR + idx_ext;
        scratch_mem_in         = rnd_q12(L_add_in[L_SHR_R_AMT+15 -: 17]);
      end
      StCmbWrm: begin
        scratch_mem_write_en   = 1'b1;
        scratch_mem_write_addr = A_ADDR + (11'd11 - idx_ext);
        scratch_mem_in         = rnd_q12(L_sub_in[L_SHR_R_AMT+15 -: 17]);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lsp_az_combine.sv
// Directed bench for lsp_az_combine with behavioural scratch RAM and saturating L_add/L_sub.
module tb_lsp_az_combine;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        done;
  logic [10:0] raddr, waddr;
  logic [31:0] mem_rd, win;
  logic        wen;
  logic [31:0] add_a, add_b, add_y, sub_a, sub_b, sub_y;
  logic        ovf_tie = 1'b0;

  logic [31:0] mem [0:2047];
  logic        ld_en = 1'b0;
  logic [10:0] ld_addr = 11'd0;
  logic [31:0] ld_data = 32'd0;
  int          wr_count = 0;

  int compared = 0;
  int mismatched = 0;

  logic [31:0] f1 [0:5];
  logic [31:0] f2 [0:5];
  logic [31:0] ea [0:10];
  int          dcyc, first_d, second_d, ndone, w0;

  always #5 clock = ~clock;

  lsp_az_combine dut (
    .clock                 (clock),
    .reset                 (reset),
    .start                 (start),
    .done                  (done),
    .scratch_mem_read_addr (raddr),
    .scratch_mem_out       (mem_rd),
    .scratch_mem_write_addr(waddr),
    .scratch_mem_in        (win),
    .scratch_mem_write_en  (wen),
    .L_add_outa            (add_a),
    .L_add_outb            (add_b),
    .L_add_in              (add_y),
    .L_add_overflow        (ovf_tie),
    .L_sub_outa            (sub_a),
    .L_sub_outb            (sub_b),
    .L_sub_in              (sub_y),
    .L_sub_overflow        (ovf_tie)
  );

  function automatic logic [31:0] sat32(input logic signed [32:0] s);
    if (s > 33'sd2147483647) return 32'h7FFF_FFFF;
    if (s < -33'sd2147483648) return 32'h8000_0000;
    return s[31:0];
  endfunction

  assign add_y = sat32($signed({add_a[31], add_a}) + $signed({add_b[31], add_b}));
  assign sub_y = sat32($signed({sub_a[31], sub_a}) - $signed({sub_b[31], sub_b}));

  always @(posedge clock) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (wen) mem[waddr] <= win;
    if (wen) wr_count <= wr_count + 1;
    mem_rd <= mem[raddr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load_mem();
    for (int k = 0; k < 23; k++) begin
      ld_en   = 1'b1;
      ld_addr = 11'(k);
      ld_data = (k < 6) ? f1[k] : (k < 12) ? f2[k-6] : 32'hDEAD_BEEF;
      @(posedge clock); #1;
    end
    ld_en = 1'b0;
  endtask

  // Returns the cycle (start-sampling cycle = 0) in which done is first seen, -1 on timeout.
  task automatic run_conv(input string tag, output int dc);
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    dc = -1;
    for (int c = 1; c <= 200; c++) begin
      if (done) begin
        dc = c;
        break;
      end
      @(posedge clock); #1;
    end
    chk({tag, "_done_cycle"}, 32'(dc), 32'd67);
    @(posedge clock); #1;
    chk({tag, "_done_pulse"}, {31'b0, done}, 32'd0);
  endtask

  task automatic check_a(input string tag);
    for (int k = 0; k <= 10; k++) chk($sformatf("%s_a%0d", tag, k), mem[12+k], ea[k]);
  endtask

  task automatic clear_f();
    for (int k = 0; k < 6; k++) begin
      f1[k] = 32'd0;
      f2[k] = 32'd0;
    end
    for (int k = 0; k <= 10; k++) ea[k] = 32'd0;
    ea[0] = 32'h0000_1000;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_done"}, {31'b0, done}, 32'd0);
    chk({tag, "_wen"}, {31'b0, wen}, 32'd0);
    chk({tag, "_raddr"}, {21'b0, raddr}, 32'd0);
    chk({tag, "_waddr"}, {21'b0, waddr}, 32'd0);
    chk({tag, "_wdata"}, win, 32'd0);
    chk({tag, "_add_a"}, add_a, 32'd0);
    chk({tag, "_add_b"}, add_b, 32'd0);
    chk({tag, "_sub_a"}, sub_a, 32'd0);
    chk({tag, "_sub_b"}, sub_b, 32'd0);
  endtask

  initial begin
    #3;
    check_idle_outputs("rst");
    #20 reset = 1'b1;
    @(posedge clock); #1;

    // Unit F1[0]=F2[0]: a[0]=a[10]=4096
    clear_f();
    f1[0] = 32'h0100_0000;
    f2[0] = 32'h0100_0000;
    ea[10] = 32'h0000_1000;
    load_mem();
    w0 = wr_count;
    run_conv("unit", dcyc);
    chk("unit_writes", 32'(wr_count - w0), 32'd21);
    chk("unit_f1_1", mem[1], 32'h0100_0000);
    chk("unit_f2_1", mem[7], 32'hFF00_0000);
    check_a("unit");

    // Rounding up: 0x1000 propagates to F1[2] as well
    clear_f();
    f1[1] = 32'h0000_1000;
    ea[1] = 32'd1; ea[2] = 32'd1; ea[9] = 32'd1; ea[10] = 32'd1;
    load_mem();
    run_conv("rnd_up", dcyc);
    check_a("rnd_up");

    clear_f();
    f1[1] = 32'h0000_0FFF;
    load_mem();
    run_conv("rnd_dn", dcyc);
    check_a("rnd_dn");

    clear_f();
    f1[1] = 32'hFFFF_F000;
    load_mem();
    run_conv("rnd_neg", dcyc);
    chk("rnd_neg_f1_2", mem[2], 32'hFFFF_F000);
    check_a("rnd_neg");

    // L_add saturation; rnd(0x7FFFFFFF) wraps to 0 in the low 16 bits
    clear_f();
    f1[4] = 32'h7FFF_FFFF;
    f1[5] = 32'h7FFF_FFFF;
    load_mem();
    run_conv("sat", dcyc);
    chk("sat_f1_5", mem[5], 32'h7FFF_FFFF);
    chk("sat_f1_4", mem[4], 32'h7FFF_FFFF);
    check_a("sat");

    // Mixed F1/F2 contributions
    clear_f();
    f1[0] = 32'h0100_0000; f1[1] = 32'h0020_0000;
    f2[0] = 32'h0100_0000; f2[1] = 32'h0010_0000;
    ea[1] = 32'd384; ea[2] = 32'd128; ea[9] = 32'd384; ea[10] = 32'd4224;
    load_mem();
    run_conv("mix", dcyc);
    chk("mix_f2_1", mem[7], 32'hFF10_0000);
    chk("mix_f2_2", mem[8], 32'hFFF0_0000);
    check_a("mix");

    // Negative coefficient must sign-extend
    clear_f();
    f2[0] = 32'h0040_0000;
    ea[1] = 32'hFFFF_FE00; ea[10] = 32'd512;
    load_mem();
    run_conv("neg", dcyc);
    chk("neg_f2_1", mem[7], 32'hFFC0_0000);
    check_a("neg");

    // start held for 80 cycles: busy start ignored, next conversion begins from IDLE at 68
    w0 = wr_count;
    first_d = -1;
    second_d = -1;
    ndone = 0;
    start = 1'b1;
    for (int c = 1; c <= 201; c++) begin
      @(posedge clock); #1;
      if (c == 80) start = 1'b0;
      if (done) begin
        ndone++;
        if (first_d < 0) first_d = c;
        else if (second_d < 0) second_d = c;
      end
    end
    chk("hold_first_done", 32'(first_d), 32'd67);
    chk("hold_second_done", 32'(second_d), 32'd135);
    chk("hold_ndone", 32'(ndone), 32'd2);
    chk("hold_writes", 32'(wr_count - w0), 32'd42);

    // Async reset mid-FIX (cycle 20), then a clean rerun
    clear_f();
    f1[0] = 32'h0100_0000; f1[1] = 32'h0020_0000;
    f2[0] = 32'h0100_0000; f2[1] = 32'h0010_0000;
    ea[1] = 32'd384; ea[2] = 32'd128; ea[9] = 32'd384; ea[10] = 32'd4224;
    load_mem();
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (19) @(posedge clock);
    #1;
    chk("mid_add_a_live", add_a, 32'h0020_0000);
    #2 reset = 1'b0;
    #1;
    check_idle_outputs("mid_rst");
    #3 reset = 1'b1;
    w0 = wr_count;
    repeat (5) @(posedge clock);
    #1;
    chk("mid_rst_no_resume", 32'(wr_count - w0), 32'd0);
    load_mem();
    run_conv("rerun", dcyc);
    check_a("rerun");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
